ama_riscv_mem_rv_lat: RTL and testbench
=======================================

// Module: ama_riscv_mem_rv_lat
// PURPOSE
//  Parametrised ready/valid memory model. Successor to the fixed-delay instruction memory.
//  Single request channel carries reads and byte-strobed writes; responses return in
//  order after D cycles. Supports up to OUTST requests in flight, rsp-side backpressure
//  and an out-of-range error flag.
//  Instantiated by core top as IMEM (WRITE_EN=0) or as unified/data memory (WRITE_EN=1).
// PARAMETERS
//  AW        16    request word-address width
//  DW        32    data width; must be a multiple of 8; NB = DW/8
//  MEM_WORDS 4096  implemented words, valid addr 0..MEM_WORDS-1, MEM_WORDS <= 2**AW
//  D         2     request-to-response latency in cycles, D >= 1
//  OUTST     4     max outstanding requests (pipeline + rsp buffer), power of 2, >= 1
//  WRITE_EN  1     0: req_we ignored, every request is a read
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      asynchronous, active-low reset
//  req_valid  in   1      request valid
//  req_ready  out  1      request accept
//  req_addr   in   AW     word address
//  req_we     in   NB     byte write strobes; all-zero = read
//  req_wdata  in   DW     write data
//  rsp_valid  out  1      response valid
//  rsp_ready  in   1      response accept
//  rsp_data   out  DW     read data; 0 for writes and errors
//  rsp_err    out  1      request address >= MEM_WORDS
//  busy       out  1      cnt != 0
// BEHAVIOUR
//  - Reset (rst=0, async): pipeline valids, buffer pointers and cnt clear. Memory array is not reset.
//    Outputs during reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
//    req_ready=1 in the first cycle after rst deasserts.
//  - Accept = req_valid & req_ready. Fire = rsp_valid & rsp_ready.
//  - cnt (width clog2(OUTST)+1): +1 on accept, -1 on fire, unchanged when both occur.
//    req_ready = (cnt < OUTST), registered-state only, with no combinational path from rsp_ready.
//  - Read at accept edge N: the word is sampled from the array at that edge.
//    Result moves through D-1 delay stages into the rsp buffer.
//    rsp_valid is first visible in cycle N+D when the buffer ahead of it is empty.
//  - Write (WRITE_EN=1, req_we!=0): byte lanes with we[i]=1 update at the accept edge.
//    It still produces a response: data 0, err per address, same D latency, same ordering.
//  - Read following a write to the same address (any later cycle) returns the new data.
//  - Out of range (addr >= MEM_WORDS): write ignored, rsp_data=0, rsp_err=1.
//  - Responses are strictly in acceptance order.
//    rsp_data/rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
//  - Rsp buffer depth is OUTST, so it never overflows: cnt bounds pipeline+buffer occupancy.
//    Full (cnt=OUTST): req_ready=0 until a fire.
//  - Pointers wrap modulo OUTST. Pipeline stages never stall.
//    Backpressure is absorbed only by the buffer and the cnt credit.
//  - busy = (cnt != 0). Reset mid-operation drops all in-flight responses.
//    Completed writes persist.
// TESTING
//  - Reset: hold rst=0 with req_valid=1 -> req_ready=0, rsp_valid=0, no write.
//    Release -> req_ready=1 next cycle.
//  - Latency, D=2, rsp_ready=1: read addr 0x10 (mem=0xDEADBEEF) accepted at cycle 5
//    -> rsp_valid=1 only in cycle 7, data 0xDEADBEEF, err=0.
//  - Byte write: we=4'b0101, wdata=0x11223344 to word holding 0xAABBCCDD, then read
//    -> rsp_data=0xAA22CC44. Same with WRITE_EN=0 -> 0xAABBCCDD.
//  - Backpressure, OUTST=4: rsp_ready=0, back-to-back reads of 1,2,3,4,5
//    -> 4 accepted, req_ready=0. Raise rsp_ready -> data in order 1..4, then 5 accepted.
//  - Simultaneous accept+fire at cnt=OUTST-1 for 20 cycles -> cnt constant.
//    Throughput is 1/cycle; no loss or duplication across pointer wrap.
//  - Addr=MEM_WORDS write 0xFFFFFFFF then read addr=MEM_WORDS -> both rsp_err=1, data 0.
//    Reset asserted with 3 in flight -> no responses emitted after release.

Source files
------------

// File: rtl/ama_riscv_mem_rv_lat.sv
// ama_riscv_mem_rv_lat
//   Ready/valid memory model with a fixed request-to-response latency.
//   A single request channel carries reads and byte-strobed writes. Every
//   accepted request produces exactly one response. Responses return in
//   acceptance order, D cycles after the accept edge at the earliest.
//   Up to OUTST requests may be in flight. Response-side backpressure is
//   absorbed by an OUTST-deep response buffer and by the credit counter.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   req_valid  in   1   request valid
//   req_ready  out  1   request accept (cnt < OUTST)
//   req_addr   in   AW  word address
//   req_we     in   NB  byte write strobes, all-zero = read
//   req_wdata  in   DW  write data
//   rsp_valid  out  1   response valid
//   rsp_ready  in   1   response accept
//   rsp_data   out  DW  read data (0 for writes and out-of-range)
//   rsp_err    out  1   request address was >= MEM_WORDS
//   busy       out  1   requests in flight
module ama_riscv_mem_rv_lat #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MEM_WORDS = 4096,
  parameter int D         = 2,
  parameter int OUTST     = 4,
  parameter int WRITE_EN  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW/8-1:0] req_we,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            busy
);

  localparam int NB = DW / 8;
  localparam int CW = $clog2(OUTST) + 1;
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [AW:0]   LIMIT = (AW+1)'(MEM_WORDS);
  localparam logic [CW-1:0] FULL  = CW'(OUTST);
  localparam logic [PW-1:0] LAST  = PW'(OUTST - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [DW-1:0] mem [MEM_WORDS];

  logic          accept;
  logic          fire;
  logic          oor;
  logic          is_wr;
  logic [IW-1:0] idx;
  logic [DW-1:0] in_data;
  logic [CW-1:0] cnt;

  logic          wr_vld;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  logic [DW-1:0]    buf_data [OUTST];
  logic [OUTST-1:0] buf_err;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    bcnt;

  // Ready depends only on the credit register (and reset), never on rsp_ready.
  assign req_ready = rst & (cnt != FULL);
  assign accept    = req_valid & req_ready;
  assign fire      = rsp_valid & rsp_ready;
  assign busy      = (cnt != '0);

  assign oor     = ({1'b0, req_addr} >= LIMIT);
  assign idx     = req_addr[IW-1:0];
  assign is_wr   = (WRITE_EN != 0) && (req_we != '0);
  assign in_data = (is_wr || oor) ? '0 : mem[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case ({accept, fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Array write at the accept edge; out-of-range writes are dropped.
  if (WRITE_EN != 0) begin : g_write
    always_ff @(posedge clk) begin
      if (accept && is_wr && !oor) begin
        for (int i = 0; i < NB; i++) begin
          if (req_we[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Stage 0 samples the array at the accept edge; D-1 stages feed the buffer.
  if (D == 1) begin : g_direct
    assign wr_vld  = accept;
    assign wr_data = in_data;
    assign wr_err  = oor;
  end else begin : g_pipe
    logic [D-2:0]  vld_p;
    logic [D-2:0]  err_p;
    logic [DW-1:0] data_p [D-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= accept;
        for (int i = 1; i < D-1; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      data_p[0] <= in_data;
      err_p[0]  <= oor;
      for (int i = 1; i < D-1; i++) begin
        data_p[i] <= data_p[i-1];
        err_p[i]  <= err_p[i-1];
      end
    end

    assign wr_vld  = vld_p[D-2];
    assign wr_data = data_p[D-2];
    assign wr_err  = err_p[D-2];
  end

  // Response buffer: cnt bounds total occupancy, so a write never hits a full buffer.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      buf_data[wr_ptr] <= wr_data;
      buf_err[wr_ptr]  <= wr_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bcnt   <= '0;
    end else begin
      if (wr_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (fire)   rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_vld, fire})
        2'b10:   bcnt <= bcnt + 1'b1;
        2'b01:   bcnt <= bcnt - 1'b1;
        default: bcnt <= bcnt;
      endcase
    end
  end

  assign rsp_valid = (bcnt != '0);
  assign rsp_data  = rsp_valid ? buf_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid & buf_err[rd_ptr];

endmodule

// File: tb/tb_ama_riscv_mem_rv_lat.sv
// Bench for ama_riscv_mem_rv_lat: a writable instance (defaults) driven through
// a scoreboard, plus a read-only instance (WRITE_EN=0) for the strobe-ignore case.
module tb_ama_riscv_mem_rv_lat;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [15:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  logic        r_req_valid, r_req_ready;
  logic [15:0] r_req_addr;
  logic [3:0]  r_req_we;
  logic [31:0] r_req_wdata;
  logic        r_rsp_valid, r_rsp_ready;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err, r_busy;

  always #5 clk = ~clk;

  ama_riscv_mem_rv_lat u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  ama_riscv_mem_rv_lat #(.WRITE_EN(0)) u_ro (
    .clk(clk), .rst(rst),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_addr(r_req_addr),
    .req_we(r_req_we), .req_wdata(r_req_wdata),
    .rsp_valid(r_rsp_valid), .rsp_ready(r_rsp_ready), .rsp_data(r_rsp_data),
    .rsp_err(r_rsp_err), .busy(r_busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   rsp_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      rsp_seen++;
      chk("rsp_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input bit push);
    bit ok = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        if (push) sb.push_back({ed, ee});
      end
      tick();
      if (ok) break;
    end
    req_valid = 1'b0;
    chk("accept_in_time", ok, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("drain", ok, 1);
  endtask

  task automatic ro_txn(input string tag, input logic [15:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [31:0] ed);
    bit acc = 0;
    bit got = 0;
    r_req_valid = 1'b1;
    r_req_addr  = a;
    r_req_we    = we;
    r_req_wdata = wd;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (r_req_ready) acc = 1;
      tick();
      if (acc) break;
    end
    r_req_valid = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (r_rsp_valid) begin
        got = 1;
        chk(tag, r_rsp_data, ed);
        chk("ro_err", r_rsp_err, 0);
      end
      tick();
      if (got) break;
    end
    chk("ro_rsp_in_time", {acc, got}, 2'b11);
  endtask

  int acc_n;
  int seen0;
  bit ok5;

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b1;
    req_addr    = 16'h0020;
    req_we      = 4'hF;
    req_wdata   = 32'h1234_5678;
    rsp_ready   = 1'b1;
    r_req_valid = 1'b0;
    r_req_addr  = '0;
    r_req_we    = '0;
    r_req_wdata = '0;
    r_rsp_ready = 1'b1;

    // reset state with a request pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    tick();
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    tick();

    // latency: read accepted in cycle N is visible only in cycle N+2
    send(16'h0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    drain();
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    req_we    = 4'h0;
    @(negedge clk);
    chk("lat_accept", req_ready, 1);
    sb.push_back({32'hDEAD_BEEF, 1'b0});
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_valid", rsp_valid, 0);
    chk("lat_n1_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("lat_n2_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("lat_n3_valid", rsp_valid, 0);
    drain();

    // byte strobes
    send(16'h0030, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0, 1);
    send(16'h0030, 4'b0101, 32'h1122_3344, 32'h0, 1'b0, 1);
    send(16'h0030, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0, 1);
    drain();

    // read-only instance ignores strobes and answers as a read
    u_ro.mem[16] = 32'hAABB_CCDD;
    ro_txn("ro_wr_as_read", 16'h0010, 4'b0101, 32'h1122_3344, 32'hAABB_CCDD);
    ro_txn("ro_read_unchanged", 16'h0010, 4'h0, 32'h0, 32'hAABB_CCDD);

    // backpressure: only OUTST accepted while responses are held
    for (int i = 1; i <= 5; i++) send(16'(i), 4'hF, 32'(i), 32'h0, 1'b0, 1);
    drain();
    rsp_ready = 1'b0;
    acc_n     = 0;
    req_valid = 1'b1;
    req_we    = 4'h0;
    req_addr  = 16'd1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({32'(acc_n + 1), 1'b0});
        acc_n++;
      end
      tick();
      req_addr = 16'(acc_n + 1);
    end
    chk("bp_accepted", acc_n, 4);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_hold_data0", rsp_data, 1);
    tick();
    @(negedge clk);
    chk("bp_hold_data1", rsp_data, 1);
    chk("bp_hold_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b1;
    ok5 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back({32'd5, 1'b0});
        ok5 = 1;
      end
      tick();
      if (ok5) break;
    end
    req_valid = 1'b0;
    chk("bp_fifth_accepted", ok5, 1);
    drain();

    // sustained accept+fire at cnt = OUTST-1 across pointer wrap
    for (int i = 0; i < 23; i++) send(16'(16'h0100 + i), 4'hF, 32'h5A00_0000 + 32'(i), 32'h0, 1'b0, 1);
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(16'h0100 + i), 4'h0, 32'h0, 32'h5A00_0000 + 32'(i), 1'b0, 1);
    repeat (3) tick();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 4'h0;
    for (int k = 0; k < 20; k++) begin
      req_addr = 16'(16'h0103 + k);
      @(negedge clk);
      chk("sus_ready", req_ready, 1);
      chk("sus_valid", rsp_valid, 1);
      sb.push_back({32'h5A00_0003 + 32'(k), 1'b0});
      tick();
    end
    req_valid = 1'b0;
    drain();

    // address range boundaries
    send(16'd0, 4'hF, 32'h0BAD_C0DE, 32'h0, 1'b0, 1);
    send(16'd4095, 4'hF, 32'h7777_8888, 32'h0, 1'b0, 1);
    send(16'd4096, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    send(16'd4096, 4'h0, 32'h0, 32'h0, 1'b1, 1);
    send(16'd0, 4'h0, 32'h0, 32'h0BAD_C0DE, 1'b0, 1);
    send(16'd4095, 4'h0, 32'h0, 32'h7777_8888, 1'b0, 1);
    drain();

    // reset with requests in flight: responses dropped, no write during reset
    send(16'h0020, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    drain();
    rsp_ready = 1'b0;
    send(16'h0010, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    send(16'h0030, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    send(16'h0001, 4'h0, 32'h0, 32'h0, 1'b0, 0);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    req_we    = 4'hF;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    tick();
    req_valid = 1'b0;
    req_we    = 4'h0;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    seen0     = rsp_seen;
    repeat (10) tick();
    chk("no_rsp_after_rst", rsp_seen - seen0, 0);
    send(16'h0020, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
